tlb_cam: RTL

TLB_CAM -- requirements
Module: tlb_cam

---
 rtl/tlb_cam.sv | 108 ++++++++++
 1 files changed

// File: rtl/tlb_cam.sv
// tlb_cam: fully associative translation cache with priority lookup and round-robin replacement
module tlb_cam #(
    parameter int VPN_W   = 20,
    parameter int PPN_W   = 20,
    parameter int ENTRIES = 8,
    parameter int IDX_W   = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             lkup_vld,
    input  logic [VPN_W-1:0] lkup_vpn,
    input  logic             fill_vld,
    input  logic [VPN_W-1:0] fill_vpn,
    input  logic [PPN_W-1:0] fill_ppn,
    input  logic             flush,
    output logic             rsp_vld,
    output logic             rsp_hit,
    output logic [IDX_W-1:0] rsp_idx,
    output logic [PPN_W-1:0] rsp_ppn,
    output logic [IDX_W:0]   num_valid
);
    logic [ENTRIES-1:0] r_vld;
    logic [VPN_W-1:0]   r_tag [ENTRIES];
    logic [PPN_W-1:0]   r_ppn [ENTRIES];
    logic [IDX_W-1:0]   r_victim;
    logic               r_armed;
    logic               w_lk_hit;
    logic               w_fl_hit;
    logic               w_has_free;
    logic [IDX_W-1:0]   w_lk_idx;
    logic [IDX_W-1:0]   w_fl_idx;
    logic [IDX_W-1:0]   w_free_idx;
    logic [IDX_W-1:0]   w_tgt_idx;
    logic               w_lk_take;
    logic               w_fill_en;

    // Parallel tag compare for lookup and fill; scanning downward leaves the lowest index
    always_comb begin
        w_lk_hit   = 1'b0;
        w_fl_hit   = 1'b0;
        w_has_free = 1'b0;
        w_lk_idx   = '0;
        w_fl_idx   = '0;
        w_free_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (r_vld[i] && r_tag[i] == lkup_vpn) begin
                w_lk_hit = 1'b1;
                w_lk_idx = IDX_W'(i);
            end
            if (r_vld[i] && r_tag[i] == fill_vpn) begin
                w_fl_hit = 1'b1;
                w_fl_idx = IDX_W'(i);
            end
            if (!r_vld[i]) begin
                w_has_free = 1'b1;
                w_free_idx = IDX_W'(i);
            end
        end
    end

    assign w_tgt_idx = w_fl_hit ? w_fl_idx : (w_has_free ? w_free_idx : r_victim);
    assign w_fill_en = fill_vld && !flush;
    assign w_lk_take = lkup_vld && r_armed;

    // Valid bits, occupancy count and victim pointer; flush wins over fill
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld     <= '0;
            r_victim  <= '0;
            num_valid <= '0;
        end else if (flush) begin
            r_vld     <= '0;
            r_victim  <= '0;
            num_valid <= '0;
        end else if (fill_vld) begin
            r_vld[w_tgt_idx] <= 1'b1;
            if (!w_fl_hit && w_has_free)
                num_valid <= num_valid + {{IDX_W{1'b0}}, 1'b1};
            if (!w_fl_hit && !w_has_free)
                r_victim <= r_victim + {{(IDX_W-1){1'b0}}, 1'b1};
        end
    end

    // Tag and PPN storage needs no reset: it is never visible while its valid bit is clear
    always_ff @(posedge clk) begin
        if (w_fill_en) begin
            r_tag[w_tgt_idx] <= fill_vpn;
            r_ppn[w_tgt_idx] <= fill_ppn;
        end
    end

    // Registered lookup result from pre-update contents; the first edge after reset is swallowed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_armed <= 1'b0;
            rsp_vld <= 1'b0;
            rsp_hit <= 1'b0;
            rsp_idx <= '0;
            rsp_ppn <= '0;
        end else begin
            r_armed <= 1'b1;
            rsp_vld <= w_lk_take;
            rsp_hit <= w_lk_take && w_lk_hit;
            rsp_idx <= (w_lk_take && w_lk_hit) ? w_lk_idx : '0;
            rsp_ppn <= (w_lk_take && w_lk_hit) ? r_ppn[w_lk_idx] : '0;
        end
    end
endmodule
